// File: rtl/demux_stream_1x3.sv
// ---------------------------------------------------------------------------
// demux_stream_1x3
//
// Registered 1-to-3 stream demultiplexer. One valid/ready input beat per
// cycle is routed by IN_SELECT to one of three output streams, each backed by
// its own 2-entry FIFO so that a stalled consumer only blocks beats addressed
// to itself. IN_SELECT = 2'b11 discards the beat and bumps a saturating drop
// counter.
//
// Ports
//   CLK                     clock, rising edge
//   RST                     asynchronous, active-high reset
//   IN_VALID / IN_READY     input handshake
//   IN_SELECT [1:0]         00 -> out 1, 01 -> out 2, 10 -> out 3, 11 -> drop
//   IN_DATA [WIDTH-1:0]     input payload
//   OUT_VALID_n             buffer n non-empty
//   OUT_READY_n             consumer n takes the head this cycle
//   OUT_DATA_n              head payload of buffer n (registered storage)
//   DROP_COUNT [7:0]        saturating count of dropped beats
// ---------------------------------------------------------------------------
module demux_stream_1x3 #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       IN_SELECT,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             OUT_VALID_1,
    input  logic             OUT_READY_1,
    output logic [WIDTH-1:0] OUT_DATA_1,
    output logic             OUT_VALID_2,
    input  logic             OUT_READY_2,
    output logic [WIDTH-1:0] OUT_DATA_2,
    output logic             OUT_VALID_3,
    input  logic             OUT_READY_3,
    output logic [WIDTH-1:0] OUT_DATA_3,
    output logic [7:0]       DROP_COUNT
);

    localparam int N_OUT = 3;
    localparam logic [1:0] SEL_DROP = 2'b11;

    // Per-buffer state: occupancy, 1-bit pointers and two storage entries.
    logic [1:0]       count_q  [N_OUT];
    logic [1:0]       count_d  [N_OUT];
    logic [N_OUT-1:0] wr_ptr_q, wr_ptr_d;
    logic [N_OUT-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q    [N_OUT][2];
    logic [WIDTH-1:0] mem_d    [N_OUT][2];
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic [N_OUT-1:0] out_ready;
    logic [N_OUT-1:0] out_valid;
    logic [N_OUT-1:0] push;
    logic [N_OUT-1:0] pop;
    logic             in_fire;

    assign out_ready = {OUT_READY_3, OUT_READY_2, OUT_READY_1};

    // IN_READY looks only at registered occupancy, never at OUT_READY_n, so a
    // full buffer being popped this cycle still refuses the incoming beat.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the block leaves it unassigned (no latch).
        IN_READY = 1'b0;
        if (!RST) begin
            unique case (IN_SELECT)
                2'b00:   IN_READY = (count_q[0] != 2'd2);
                2'b01:   IN_READY = (count_q[1] != 2'd2);
                2'b10:   IN_READY = (count_q[2] != 2'd2);
                default: IN_READY = 1'b1;
            endcase
        end
    end

    assign in_fire = IN_VALID & IN_READY;

    always_comb begin
        for (int n = 0; n < N_OUT; n++) begin
            out_valid[n] = (count_q[n] != 2'd0);
            push[n]      = in_fire & (IN_SELECT == 2'(n));
            pop[n]       = out_valid[n] & out_ready[n];
        end
    end

    // Next-state for the three FIFOs. A push and pop on the same edge leave
    // the count unchanged while both pointers advance.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        for (int n = 0; n < N_OUT; n++) begin
            count_d[n] = count_q[n];
            mem_d[n]   = mem_q[n];
            unique case ({push[n], pop[n]})
                2'b10:   count_d[n] = count_q[n] + 2'd1;
                2'b01:   count_d[n] = count_q[n] - 2'd1;
                default: count_d[n] = count_q[n];
            endcase
            if (push[n]) begin
                mem_d[n][wr_ptr_q[n]] = IN_DATA;
            end
        end
    end

    // Drop counter saturates at 255 rather than wrapping.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (in_fire && (IN_SELECT == SEL_DROP) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // NOTE: storage is reset along with the control state because OUT_DATA_n
    // must read 0 after reset, not whatever the RAM cells powered up with.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int n = 0; n < N_OUT; n++) begin
                count_q[n]  <= 2'd0;
                mem_q[n][0] <= '0;
                mem_q[n][1] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            for (int n = 0; n < N_OUT; n++) begin
                count_q[n] <= count_d[n];
                mem_q[n]   <= mem_d[n];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign OUT_VALID_1 = out_valid[0];
    assign OUT_VALID_2 = out_valid[1];
    assign OUT_VALID_3 = out_valid[2];
    assign OUT_DATA_1  = mem_q[0][rd_ptr_q[0]];
    assign OUT_DATA_2  = mem_q[1][rd_ptr_q[1]];
    assign OUT_DATA_3  = mem_q[2][rd_ptr_q[2]];
    assign DROP_COUNT  = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_1x3.sv
// ---------------------------------------------------------------------------
// tb_demux_stream_1x3
//
// Directed testbench for demux_stream_1x3. Inputs change 1 time unit after a
// rising edge; outputs are compared 1-2 time units after the edge, well away
// from the next one. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_demux_stream_1x3;

    localparam int WIDTH = 32;

    logic             CLK;
    logic             RST;
    logic             IN_VALID;
    logic             IN_READY;
    logic [1:0]       IN_SELECT;
    logic [WIDTH-1:0] IN_DATA;
    logic             OUT_VALID_1, OUT_VALID_2, OUT_VALID_3;
    logic             OUT_READY_1, OUT_READY_2, OUT_READY_3;
    logic [WIDTH-1:0] OUT_DATA_1, OUT_DATA_2, OUT_DATA_3;
    logic [7:0]       DROP_COUNT;

    int err_cnt = 0;
    int chk_cnt = 0;

    demux_stream_1x3 #(.WIDTH(WIDTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_SELECT  (IN_SELECT),
        .IN_DATA    (IN_DATA),
        .OUT_VALID_1(OUT_VALID_1),
        .OUT_READY_1(OUT_READY_1),
        .OUT_DATA_1 (OUT_DATA_1),
        .OUT_VALID_2(OUT_VALID_2),
        .OUT_READY_2(OUT_READY_2),
        .OUT_DATA_2 (OUT_DATA_2),
        .OUT_VALID_3(OUT_VALID_3),
        .OUT_READY_3(OUT_READY_3),
        .OUT_DATA_3 (OUT_DATA_3),
        .DROP_COUNT (DROP_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive the input stream and let combinational outputs settle.
    task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] d);
        IN_VALID  = v;
        IN_SELECT = sel;
        IN_DATA   = d;
        #1;
    endtask

    logic [31:0] iso_data [4] = '{32'hD000_0001, 32'hD000_0002, 32'hD000_0003, 32'hD000_0004};

    initial begin
        RST         = 1'b1;
        IN_VALID    = 1'b0;
        IN_SELECT   = 2'b00;
        IN_DATA     = '0;
        OUT_READY_1 = 1'b1;
        OUT_READY_2 = 1'b1;
        OUT_READY_3 = 1'b1;

        // ---- power-on reset --------------------------------------------
        tick();
        tick();
        check("por_in_ready", IN_READY, 0);
        check("por_valid", {OUT_VALID_3, OUT_VALID_2, OUT_VALID_1}, 0);
        check("por_drop", DROP_COUNT, 0);
        RST = 1'b0;

        // ---- routing: one beat to each output --------------------------
        drive(1, 2'b00, 32'hA000_0001);
        check("rt_ready0", IN_READY, 1);
        tick();
        check("rt1_valid", OUT_VALID_1, 1);
        check("rt1_data", OUT_DATA_1, 32'hA000_0001);
        check("rt1_others", {OUT_VALID_3, OUT_VALID_2}, 0);
        drive(1, 2'b01, 32'hB000_0002);
        tick();
        check("rt2_valid", OUT_VALID_2, 1);
        check("rt2_data", OUT_DATA_2, 32'hB000_0002);
        check("rt2_others", {OUT_VALID_3, OUT_VALID_1}, 0);
        drive(1, 2'b10, 32'hC000_0003);
        tick();
        check("rt3_valid", OUT_VALID_3, 1);
        check("rt3_data", OUT_DATA_3, 32'hC000_0003);
        check("rt3_others", {OUT_VALID_2, OUT_VALID_1}, 0);
        drive(0, 2'b00, 32'h0);
        tick();
        check("rt_drained", {OUT_VALID_3, OUT_VALID_2, OUT_VALID_1}, 0);

        // ---- backpressure on buffer 1 ----------------------------------
        OUT_READY_1 = 1'b0;
        drive(1, 2'b00, 32'h11);
        check("bp_rdy_a", IN_READY, 1);
        tick();
        drive(1, 2'b00, 32'h22);
        check("bp_rdy_b", IN_READY, 1);
        tick();
        drive(1, 2'b00, 32'h33);
        check("bp_full", IN_READY, 0);
        tick();
        check("bp_head", OUT_DATA_1, 32'h11);
        OUT_READY_1 = 1'b1;
        #1;
        check("bp_no_comb_path", IN_READY, 0);
        tick();                                  // pops 0x11, 0x33 refused
        check("bp_pop1_valid", OUT_VALID_1, 1);
        check("bp_pop1_data", OUT_DATA_1, 32'h22);
        check("bp_rdy_after_pop", IN_READY, 1);
        tick();                                  // pops 0x22, accepts 0x33
        drive(0, 2'b00, 32'h0);
        check("bp_pop2_valid", OUT_VALID_1, 1);
        check("bp_pop2_data", OUT_DATA_1, 32'h33);
        tick();
        check("bp_empty", OUT_VALID_1, 0);

        // ---- isolation: buffer 1 full, stream to output 3 --------------
        OUT_READY_1 = 1'b0;
        drive(1, 2'b00, 32'h44);
        tick();
        drive(1, 2'b00, 32'h55);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'b10, iso_data[i]);
            check($sformatf("iso_rdy%0d", i), IN_READY, 1);
            tick();
            check($sformatf("iso_valid%0d", i), OUT_VALID_3, 1);
            check($sformatf("iso_data%0d", i), OUT_DATA_3, iso_data[i]);
        end
        drive(1, 2'b00, 32'h66);
        check("iso_b1_full", IN_READY, 0);
        check("iso_b1_head", OUT_DATA_1, 32'h44);
        drive(0, 2'b00, 32'h0);
        OUT_READY_1 = 1'b1;
        tick();
        check("iso_b3_empty", OUT_VALID_3, 0);
        check("iso_b1_second", OUT_DATA_1, 32'h55);
        tick();
        check("iso_b1_empty", OUT_VALID_1, 0);

        // ---- simultaneous push/pop on buffer 2 -------------------------
        OUT_READY_2 = 1'b0;
        drive(1, 2'b01, 32'h77);
        tick();
        check("pp_one", OUT_DATA_2, 32'h77);
        OUT_READY_2 = 1'b1;
        drive(1, 2'b01, 32'h88);
        tick();                                  // pop 0x77, push 0x88
        drive(0, 2'b00, 32'h0);
        check("pp_valid", OUT_VALID_2, 1);
        check("pp_data", OUT_DATA_2, 32'h88);
        tick();
        check("pp_empty", OUT_VALID_2, 0);

        // ---- drop saturation -------------------------------------------
        for (int i = 0; i < 300; i++) begin
            drive(1, 2'b11, 32'hDEAD_0000 + 32'(i));
            check("drop_rdy", IN_READY, 1);
            tick();
            check("drop_cnt", DROP_COUNT, (i + 1 > 255) ? 255 : i + 1);
            check("drop_no_valid", {OUT_VALID_3, OUT_VALID_2, OUT_VALID_1}, 0);
        end
        drive(0, 2'b00, 32'h0);
        tick();
        check("drop_hold", DROP_COUNT, 255);

        // ---- reset mid-stream with buffer 2 holding two beats ----------
        OUT_READY_2 = 1'b0;
        drive(1, 2'b01, 32'h9000_0001);
        tick();
        drive(1, 2'b01, 32'h9000_0002);
        tick();
        drive(1, 2'b01, 32'h9000_0003);
        check("rs_b2_full", IN_READY, 0);
        RST = 1'b1;
        #1;
        check("rs_valid", {OUT_VALID_3, OUT_VALID_2, OUT_VALID_1}, 0);
        check("rs_data1", OUT_DATA_1, 0);
        check("rs_data2", OUT_DATA_2, 0);
        check("rs_data3", OUT_DATA_3, 0);
        check("rs_drop", DROP_COUNT, 0);
        check("rs_in_ready", IN_READY, 0);
        tick();
        RST = 1'b0;
        drive(1, 2'b01, 32'h1234_5678);
        check("rs_release_rdy", IN_READY, 1);
        tick();
        drive(0, 2'b00, 32'h0);
        check("rs_first_valid", OUT_VALID_2, 1);
        check("rs_first_data", OUT_DATA_2, 32'h1234_5678);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/demux_stream_1x3.md
# demux_stream_1x3

Registered 1-to-3 stream demultiplexer: the distribution-side counterpart of the 3:1 datapath mux. It accepts one beat per cycle on a valid/ready input stream and routes it by a 2-bit destination code to one of three valid/ready output streams. Each output has its own 2-entry FIFO buffer, so a stalled destination does not block traffic to the others once its buffer is full of its own beats. It sits between a single producer (e.g. a decode/issue stage) and three independent consumers.

## Interface
- WIDTH, 32, data width of input and all outputs
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  asynchronous, active-high reset
- IN_VALID  input  1  input beat present
- IN_READY  output  1  input beat accepted this cycle when IN_VALID=1
- IN_SELECT  input  2  destination code: 2'b00 → out 1, 2'b01 → out 2, 2'b10 → out 3, 2'b11 → drop
- IN_DATA  input  WIDTH  input payload
- OUT_VALID_1/2/3  output  1  head of buffer n valid
- OUT_READY_1/2/3  input  1  consumer n takes head this cycle
- OUT_DATA_1/2/3  output  WIDTH  head payload of buffer n
- DROP_COUNT  output  8  saturating count of accepted beats with IN_SELECT=2'b11

## Operation
- Input transfer: IN_VALID & IN_READY on a rising edge. Output transfer n: OUT_VALID_n & OUT_READY_n.
- Three independent 2-entry FIFOs, each with 2-bit occupancy count (0..2), 1-bit read/write pointers.
- IN_READY (combinational, from registered state and IN_SELECT only):
  - RST high → 0.
  - IN_SELECT 2'b00/01/10 → 1 iff selected buffer's count < 2.
  - IN_SELECT 2'b11 → 1 (drop path always ready).
  - No combinational path from OUT_READY_n to IN_READY: full buffer popped in same cycle still refuses input that cycle.
- Accepted beat to code 0..2: written to that buffer at write pointer; pointer toggles; count +1 unless same-cycle pop of that buffer.
- Accepted beat to 2'b11: payload discarded, DROP_COUNT +1, holds at 255 (no wrap).
- OUT_VALID_n = (count_n != 0); OUT_DATA_n = entry at read pointer, registered storage, no combinational path from IN_DATA.
- OUT_DATA_n when OUT_VALID_n=0: holds last-written storage value (0 after reset); consumers must not sample.
- Simultaneous push and pop on same buffer: count unchanged, both pointers advance, FIFO order preserved.
- Order: beats to the same output leave in acceptance order; no ordering relation between different outputs.
- IN_SELECT and IN_DATA sampled only on input transfer; changing them while IN_VALID=1 and IN_READY=0 is legal (no AXI-style stability requirement).

## Timing
- Reset (RST asserted, any time including mid-transfer): all counts, pointers, storage, DROP_COUNT → 0; OUT_VALID_1/2/3=0, OUT_DATA_1/2/3=0, IN_READY=0. In-flight beats are lost. First transfer possible on first rising edge after RST deasserts.
- Latency: beat accepted on edge k is on OUT_VALID_n/OUT_DATA_n after edge k (visible in cycle k+1); earliest pop at edge k+1.
- Throughput: 1 beat/cycle sustained to any single output whose consumer holds OUT_READY_n=1; 2 beats absorbed with consumer stalled, then IN_READY=0 for that code.
- DROP_COUNT updates on edge of the dropped transfer.

## Test plan
- Reset: assert RST mid-stream with buffer 2 holding 2 beats → immediately OUT_VALID_*=0, OUT_DATA_*=0, DROP_COUNT=0, IN_READY=0; after release IN_READY=1 for IN_SELECT=2'b01.
- Routing: send 0xA0000001 sel 00, 0xB0000002 sel 01, 0xC0000003 sel 10 on consecutive edges, all OUT_READY=1 → each appears exactly once on its output one cycle after acceptance, others stay invalid.
- Backpressure/full: OUT_READY_1=0, send 0x11, 0x22, 0x33 to sel 00 → first two accepted, IN_READY=0 for third; raise OUT_READY_1 → 0x11 then 0x22 popped; 0x33 accepted only on the cycle after first pop; order 0x11,0x22,0x33.
- Isolation: buffer 1 full and stalled, stream 4 beats to sel 10 with OUT_READY_3=1 → all 4 accepted back-to-back, delivered in order on output 3.
- Simultaneous push/pop: buffer 2 count=1, push and pop same edge → count stays 1, OUT_VALID_2 stays 1, next data is the pushed beat.
- Drop saturation: send 300 beats with sel 11 → IN_READY=1 every cycle, no OUT_VALID asserted, DROP_COUNT=255 and holds.
